// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a same-cycle read memory.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, loads reset/interrupt vectors, assembles
// two-word instructions and handles branch redirects, stalls and interrupt entry.
module fetch_stage #(
  parameter int          IMM_FLAG_BIT   = 15,
  parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
  parameter logic [31:0] INT_VEC_ADDR   = 32'd2,
  parameter logic [15:0] NOP_WORD       = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 int_req,
  fetch_stage_if.master        imem,
  output logic [31:0]          PC_out,
  output logic [15:0]          instruction_out,
  output logic [15:0]          Data_out,
  output logic                 INT_out
);

  typedef enum logic [2:0] {
    RST_HI = 3'd0,
    RST_LO = 3'd1,
    FETCH  = 3'd2,
    IMM    = 3'd3,
    INT_HI = 3'd4,
    INT_LO = 3'd5
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [15:0] hi_tmp_r;
  logic [15:0] op_hold_r;
  logic        int_pending_r;
  logic [31:0] addr_s;
  logic [31:0] pc_inc_s;

  assign pc_inc_s       = pc_r + 32'd1;
  assign imem.imem_addr = addr_s;

  // Memory address selection from the current state and PC.
  always_comb begin
    addr_s = pc_r;
    case (state_r)
      RST_HI:  addr_s = RESET_VEC_ADDR;
      RST_LO:  addr_s = RESET_VEC_ADDR + 32'd1;
      INT_HI:  addr_s = INT_VEC_ADDR;
      INT_LO:  addr_s = INT_VEC_ADDR + 32'd1;
      FETCH:   addr_s = pc_r;
      IMM:     addr_s = pc_r;
      default: addr_s = pc_r;
    endcase
  end

  // Sequencer: PC, vector loads, instruction assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= RST_HI;
      pc_r            <= 32'd0;
      hi_tmp_r        <= 16'h0000;
      op_hold_r       <= 16'h0000;
      int_pending_r   <= 1'b0;
      PC_out          <= 32'd0;
      instruction_out <= NOP_WORD;
      Data_out        <= 16'h0000;
      INT_out         <= 1'b0;
    end else begin
      // A live request re-arms the pending flag even on the cycle it is accepted.
      int_pending_r <= int_pending_r | int_req;
      case (state_r)
        RST_HI, INT_HI: begin
          hi_tmp_r        <= imem.imem_rdata;
          instruction_out <= NOP_WORD;
          Data_out        <= 16'h0000;
          INT_out         <= 1'b0;
          state_r         <= (state_r == RST_HI) ? RST_LO : INT_LO;
        end
        RST_LO, INT_LO: begin
          pc_r            <= {hi_tmp_r, imem.imem_rdata};
          instruction_out <= NOP_WORD;
          Data_out        <= 16'h0000;
          INT_out         <= 1'b0;
          state_r         <= FETCH;
        end
        FETCH, IMM: begin
          if (branch_taken) begin
            pc_r            <= branch_target;
            instruction_out <= NOP_WORD;
            Data_out        <= 16'h0000;
            INT_out         <= 1'b0;
            state_r         <= FETCH;
          end else if (stall) begin
            state_r <= state_r;
          end else if (state_r == IMM) begin
            instruction_out <= op_hold_r;
            Data_out        <= imem.imem_rdata;
            INT_out         <= 1'b0;
            pc_r            <= pc_inc_s;
            PC_out          <= pc_inc_s;
            state_r         <= FETCH;
          end else if (int_pending_r) begin
            // Memory word is left unconsumed; PC_out becomes the return address.
            instruction_out <= NOP_WORD;
            Data_out        <= 16'h0000;
            INT_out         <= 1'b1;
            PC_out          <= pc_r;
            int_pending_r   <= int_req;
            state_r         <= INT_HI;
          end else if (imem.imem_rdata[IMM_FLAG_BIT]) begin
            op_hold_r       <= imem.imem_rdata;
            pc_r            <= pc_inc_s;
            instruction_out <= NOP_WORD;
            Data_out        <= 16'h0000;
            INT_out         <= 1'b0;
            state_r         <= IMM;
          end else begin
            instruction_out <= imem.imem_rdata;
            Data_out        <= 16'h0000;
            INT_out         <= 1'b0;
            pc_r            <= pc_inc_s;
            PC_out          <= pc_inc_s;
            state_r         <= FETCH;
          end
        end
        default: begin
          instruction_out <= NOP_WORD;
          Data_out        <= 16'h0000;
          INT_out         <= 1'b0;
          state_r         <= RST_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset vector, two-word assembly, stall, branch,
// interrupt entry, PC wrap and mid-sequence reset.
module tb_fetch_stage;
  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        int_req;
  logic [31:0] PC_out;
  logic [15:0] instruction_out;
  logic [15:0] Data_out;
  logic        INT_out;

  logic [15:0] mem [0:255];
  int          errors;
  int          checks;

  fetch_stage_if bus ();

  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .int_req         (int_req),
    .imem            (bus),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .Data_out        (Data_out),
    .INT_out         (INT_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] ins, input logic [15:0] dat,
                           input logic [31:0] pc, input logic intr);
    check({tag, ".instr"}, {16'h0000, instruction_out}, {16'h0000, ins});
    check({tag, ".data"},  {16'h0000, Data_out},        {16'h0000, dat});
    check({tag, ".pc"},    PC_out,                      pc);
    check({tag, ".int"},   {31'd0, INT_out},            {31'd0, intr});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0010;
    mem[8'h02] = 16'h0000; mem[8'h03] = 16'h0030;
    mem[8'h10] = 16'h1234; mem[8'h11] = 16'h8005; mem[8'h12] = 16'hBEEF;
    mem[8'h13] = 16'h8005; mem[8'h14] = 16'hCAFE;
    mem[8'h15] = 16'h8005; mem[8'h16] = 16'hDDDD;
    mem[8'h30] = 16'h0055;
    mem[8'h40] = 16'h0042; mem[8'h41] = 16'h8077; mem[8'h42] = 16'h1111;
    mem[8'hFF] = 16'h0099;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'd0; int_req = 1'b0;
    step(); step();
    check_out("reset", 16'h0000, 16'h0000, 32'd0, 1'b0);
    check("reset.addr", bus.imem_addr, 32'd0);

    reset = 1'b0;
    step();
    check_out("rst_hi", 16'h0000, 16'h0000, 32'd0, 1'b0);
    check("rst_lo.addr", bus.imem_addr, 32'd1);
    step();
    check("rst_lo.instr", {16'h0000, instruction_out}, 32'd0);
    check("fetch.addr", bus.imem_addr, 32'h10);
    step();
    check_out("one_word", 16'h1234, 16'h0000, 32'h11, 1'b0);

    step();
    check_out("imm_bubble", 16'h0000, 16'h0000, 32'h11, 1'b0);
    step();
    check_out("two_word", 16'h8005, 16'hBEEF, 32'h13, 1'b0);

    // Stall three cycles while in IMM.
    step();
    check_out("imm2_bubble", 16'h0000, 16'h0000, 32'h13, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 16'h0000, 16'h0000, 32'h13, 1'b0);
      check("stall.addr", bus.imem_addr, 32'h14);
    end
    stall = 1'b0;
    step();
    check_out("after_stall", 16'h8005, 16'hCAFE, 32'h15, 1'b0);

    // Branch together with stall while in IMM.
    step();
    check_out("imm3_bubble", 16'h0000, 16'h0000, 32'h15, 1'b0);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    check_out("branch", 16'h0000, 16'h0000, 32'h15, 1'b0);
    check("branch.addr", bus.imem_addr, 32'h40);
    step();
    check_out("branch_tgt", 16'h0042, 16'h0000, 32'h41, 1'b0);

    // Interrupt pulse during IMM.
    step();
    check_out("imm4_bubble", 16'h0000, 16'h0000, 32'h41, 1'b0);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    check_out("int_two_word", 16'h8077, 16'h1111, 32'h43, 1'b0);
    step();
    check_out("int_entry", 16'h0000, 16'h0000, 32'h43, 1'b1);
    check("int_hi.addr", bus.imem_addr, 32'd2);
    step();
    check_out("int_hi", 16'h0000, 16'h0000, 32'h43, 1'b0);
    check("int_lo.addr", bus.imem_addr, 32'd3);
    step();
    check_out("int_lo", 16'h0000, 16'h0000, 32'h43, 1'b0);
    check("isr.addr", bus.imem_addr, 32'h30);
    step();
    check_out("isr", 16'h0055, 16'h0000, 32'h31, 1'b0);

    // PC wrap at the top of the address space.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    check("wrap.addr_top", bus.imem_addr, 32'hFFFF_FFFF);
    step();
    check_out("wrap", 16'h0099, 16'h0000, 32'd0, 1'b0);
    check("wrap.addr", bus.imem_addr, 32'd0);

    // Second interrupt, then reset while in INT_LO.
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    check_out("pre_int", 16'h0000, 16'h0000, 32'd1, 1'b0);
    step();
    check_out("int2_entry", 16'h0000, 16'h0000, 32'd1, 1'b1);
    step();
    check("int2_lo.addr", bus.imem_addr, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("mid_reset", 16'h0000, 16'h0000, 32'd0, 1'b0);
    check("mid_reset.addr", bus.imem_addr, 32'd0);
    step();
    check("restart.addr", bus.imem_addr, 32'd1);
    step();
    step();
    check_out("restart", 16'h1234, 16'h0000, 32'h11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that directly feeds the IF/ID pipeline buffer.
- Owns the 32-bit PC and loads the reset vector from instruction memory.
- Assembles two-word (immediate) instructions into instruction + Data.
- Handles branch redirects and stalls from the hazard unit.
- Injects interrupt entry: marks it with INT_out, then loads the interrupt vector.

Parameters:
IMM_FLAG_BIT, 15, bit of the first instruction word that marks a two-word instruction (1 = immediate word follows)
RESET_VEC_ADDR, 32'd0, address of the reset vector high word; low word is at +1
INT_VEC_ADDR, 32'd2, address of the interrupt vector high word; low word is at +1
NOP_WORD, 16'h0000, instruction word emitted for bubbles

Ports:
clk  input  1  stage clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit freeze; holds PC, state and outputs
branch_taken  input  1  redirect request from a later stage
branch_target  input  32  redirect address
int_req  input  1  external interrupt request, level-sampled
imem_addr  output  32  word address to instruction memory; combinational from state/PC
imem_rdata  input  16  word at imem_addr, same-cycle (combinational) read
PC_out  output  32  registered; address of next sequential instruction (return address)
instruction_out  output  16  registered instruction word
Data_out  output  16  registered immediate word; 0 for one-word instructions
INT_out  output  1  registered; 1 for exactly one cycle to mark interrupt entry

Behaviour:
- States: RST_HI, RST_LO, FETCH, IMM, INT_HI, INT_LO.
- Reset (reset=1 at a rising edge, including mid-operation):
  - state<=RST_HI, PC<=0, int_pending<=0.
  - PC_out=0, instruction_out=NOP_WORD, Data_out=0, INT_out=0.
- Bubble: any cycle not listed below as producing an instruction registers instruction_out=NOP_WORD, Data_out=0 and INT_out=0; PC_out holds its value.
- imem_addr per state:
  - RST_HI: RESET_VEC_ADDR. RST_LO: RESET_VEC_ADDR+1.
  - INT_HI: INT_VEC_ADDR. INT_LO: INT_VEC_ADDR+1.
  - FETCH and IMM: PC.
- Vector loads:
  - RST_HI: hi_tmp<=imem_rdata, emit bubble, go to RST_LO.
  - RST_LO: PC<={hi_tmp, imem_rdata}, emit bubble, go to FETCH.
  - INT_HI/INT_LO behave the same way using the interrupt vector.
  - stall and branch_taken are ignored in all four vector states.
- int_pending: set when int_req=1 in any state; cleared when the interrupt is accepted.
- Priority in FETCH/IMM (first match wins): reset > branch_taken > stall > interrupt > normal fetch.
- branch_taken=1 in FETCH or IMM:
  - PC<=branch_target, state<=FETCH, emit bubble.
  - A half-assembled two-word instruction is discarded.
  - Branch overrides a simultaneous stall.
- stall=1, no branch: PC, state, hold register and all outputs unchanged.
- FETCH with int_pending=1 (no branch, no stall):
  - Memory word is not consumed; PC unchanged.
  - Outputs: INT_out=1, instruction_out=NOP_WORD, Data_out=0, PC_out<=PC.
  - Clear int_pending, go to INT_HI.
- Interrupts are only accepted in FETCH, never in IMM, so a two-word instruction is never split.
- FETCH, normal:
  - If imem_rdata[IMM_FLAG_BIT]=0:
    - PC<=PC+1.
    - Outputs: instruction_out<=imem_rdata, Data_out<=0, PC_out<=PC+1.
  - If imem_rdata[IMM_FLAG_BIT]=1:
    - op_hold<=imem_rdata, PC<=PC+1, emit bubble, go to IMM.
- IMM (no branch, no stall):
  - instruction_out<=op_hold, Data_out<=imem_rdata.
  - PC<=PC+1, PC_out<=PC+1, go to FETCH.
- Arithmetic: PC increments are 32-bit modulo; 32'hFFFFFFFF+1 wraps to 0 silently.
- Latency: one-word instruction appears 1 cycle after its fetch. Two-word instruction appears 2 cycles after its first word, preceded by one bubble.

Test Plan:
- Reset vector: M[0]=16'h0000, M[1]=16'h0010, M[0x10]=16'h1234; release reset -> two bubbles, then instruction_out=16'h1234, PC_out=32'h11, Data_out=0.
- Two-word: M[0x10]=16'h8005, M[0x11]=16'hBEEF -> one bubble, then instruction_out=16'h8005, Data_out=16'hBEEF, PC_out=32'h12.
- Stall, and branch vs stall: hold stall=1 for 3 cycles in IMM -> outputs and PC frozen, then the instruction completes normally. Assert branch_taken=1 with target 32'h40 together with stall=1 in IMM -> bubble, next fetch from 0x40, the 0x8005 word is discarded.
- Interrupt: pulse int_req for 1 cycle during IMM -> the two-word instruction completes first. Next cycle INT_out=1 with PC_out equal to the next address. Then two bubbles and a fetch from {M[2],M[3]}.
- Wrap: PC=32'hFFFFFFFF holding a one-word instruction -> PC_out=0, next fetch address 0.
- Reset mid-sequence: assert reset in INT_LO -> next cycle all outputs are zero/NOP and the state restarts at RST_HI.
